block_assembler: RTL
====================

# block_assembler

Parametrised successor to the header/nonce concatenator in the mining datapath. Accepts a header and a nonce range, then autonomously sweeps the nonce and streams `{header, nonce}` blocks to the hash core over a valid/ready handshake. Stops on a `found` indication from the hash core or when the range is exhausted. Sits between the header source and the hash pipeline.

## Interface
- `HDR_W`, 96, header width in bits.
- `NONCE_W`, 32, nonce width in bits; must be a multiple of 8.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- `header_in`  in  HDR_W  header; captured on an accepted `start`.
- `nonce_start`  in  NONCE_W  first nonce; captured on an accepted `start`.
- `nonce_end`  in  NONCE_W  last nonce, inclusive; captured on an accepted `start`.
- `found`  in  1  hash core reports a hit; sampled only in RUN.
- `block_ready`  in  1  downstream can accept a block.
- `block_out`  out  HDR_W+NONCE_W  `{header, nonce}`, with the header in the MSBs.
- `block_valid`  out  1  `block_out` is valid.
- `nonce_cur`  out  NONCE_W  nonce currently presented.
- `busy`  out  1  high when not in IDLE.
- `done`  out  1  one-cycle pulse at sweep end.
- `exhausted`  out  1  qualifies `done`: 1 = range finished, 0 = stopped by `found`.

## Operation
- States:
  - IDLE -> RUN on `start`.
  - RUN -> DONE on `found`, or on a transfer of the `nonce_end` block.
  - DONE -> IDLE unconditionally after one cycle.
- Accepted `start`:
  - Registers `header_in`, `nonce_start` and `nonce_end`.
  - Loads `nonce_cur = nonce_start`.
- RUN:
  - `block_valid` = 1.
  - `block_out` = {hdr_reg, nonce field}; stable while `block_valid && !block_ready`.
- Transfer = `block_valid && block_ready`.
  - On transfer with `nonce_cur != end_reg`: `nonce_cur` <= `nonce_cur + 1`, modulo 2^NONCE_W. `block_valid` stays high, so back-to-back transfers run one per cycle.
  - On transfer with `nonce_cur == end_reg`: go to DONE with `exhausted` = 1.
- `found` in RUN: go to DONE with `exhausted` = 0. `nonce_cur` is not incremented, even if a transfer occurs in the same cycle. `found` takes priority over exhaustion.
- Wrap-around:
  - `nonce_start > nonce_end`: sweep wraps through all-ones to 0 and ends at `nonce_end`.
  - `nonce_start == nonce_end`: exactly one block.
- `start` outside IDLE is ignored. Captured registers do not change mid-sweep.
- DONE:
  - `block_valid` = 0, `done` = 1, `busy` = 1.
  - `nonce_cur` holds its last value.
- Reset, asynchronous, also when asserted mid-sweep: state IDLE. All outputs 0: `block_out`, `block_valid`, `nonce_cur`, `busy`, `done`, `exhausted`. All internal registers 0. Any in-flight block is dropped.

## Timing
- `start` sampled at edge N: `block_valid` = 1 with the first block after edge N; `busy` = 1 from the same edge.
- Throughput: one block per cycle while `block_ready` = 1.
- Final transfer or `found` at edge M: `block_valid` = 0 and `done` = 1 after edge M; `done` = 0 and `busy` = 0 after edge M+1.
- Earliest new `start` is sampled at edge M+2, i.e. in IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `BLOCK_ASM_NONCE_BSWAP_EN`:
  - Defined: the nonce field of `block_out` is byte-reversed. The byte at `nonce_cur[7:0]` lands in the MSB byte of the field, giving little-endian order for the hash core. `nonce_cur` itself is unaffected.
  - Undefined: the nonce field equals `nonce_cur` unchanged.

## Test plan
- Basic sweep: header=96'hA5…A5, start=0x10, end=0x13, `block_ready` tied 1 -> 4 consecutive blocks with nonces 0x10..0x13; `done`=1 and `exhausted`=1 one cycle after the 4th transfer; then IDLE.
- Backpressure: `block_ready` low for 3 cycles on nonce 0x11 -> `block_out` held stable at 0x11, no increment, sweep then resumes at 0x12.
- Wrap: start=0xFFFFFFFE, end=0x00000001 -> nonces FFFFFFFE, FFFFFFFF, 0, 1, then `exhausted`=1.
- Found with simultaneous transfer: range 0..100, `found` asserted with the transfer of nonce 5 -> DONE with `exhausted`=0, `nonce_cur`=5, no further `block_valid`.
- Reset mid-sweep at nonce 7, then `start` with 0..0 -> all outputs 0 during reset; new sweep emits exactly one block with nonce 0.
- With `BLOCK_ASM_NONCE_BSWAP_EN` defined and nonce 0x12345678 -> `block_out[31:0]`=0x78563412.

Source files
------------

// File: rtl/block_assembler.sv
// block_assembler: captures a header and an inclusive nonce range on start, then
// sweeps the nonce and streams {header, nonce} blocks over a valid/ready handshake.
// The sweep ends on a hit from the hash core (found) or after the nonce_end block
// has been transferred.
// Optional feature macro: BLOCK_ASM_NONCE_BSWAP_EN byte-reverses the nonce field
// of block_out (little-endian order for the hash core); nonce_cur is unaffected.
module block_assembler #(
    parameter int HDR_W   = 96,
    parameter int NONCE_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [HDR_W-1:0]           header_in,
    input  logic [NONCE_W-1:0]         nonce_start,
    input  logic [NONCE_W-1:0]         nonce_end,
    input  logic                       found,
    input  logic                       block_ready,
    output logic [HDR_W+NONCE_W-1:0]   block_out,
    output logic                       block_valid,
    output logic [NONCE_W-1:0]         nonce_cur,
    output logic                       busy,
    output logic                       done,
    output logic                       exhausted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [HDR_W-1:0]     hdr_q, hdr_d;
    logic [NONCE_W-1:0]   end_q, end_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 exh_q, exh_d;
    logic [NONCE_W-1:0]   nonce_field;

    // Next-state and next-output decode; every output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        end_d   = end_q;
        nonce_d = nonce_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        exh_d   = exh_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    hdr_d   = header_in;
                    end_d   = nonce_end;
                    nonce_d = nonce_start;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    exh_d   = 1'b0;
                end
            end
            ST_RUN: begin
                // A hit wins over both exhaustion and the increment.
                if (found) begin
                    state_d = ST_DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    exh_d   = 1'b0;
                end else if (valid_q && block_ready) begin
                    if (nonce_q == end_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        exh_d   = 1'b1;
                    end else begin
                        nonce_d = nonce_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hdr_q   <= '0;
            end_q   <= '0;
            nonce_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            exh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            end_q   <= end_d;
            nonce_q <= nonce_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            exh_q   <= exh_d;
        end
    end

`ifdef BLOCK_ASM_NONCE_BSWAP_EN
    // Byte-reverse: nonce byte 0 lands in the most significant byte of the field.
    for (genvar gi = 0; gi < NONCE_W / 8; gi++) begin : g_bswap
        assign nonce_field[NONCE_W-1-8*gi -: 8] = nonce_q[8*gi +: 8];
    end
`else
    assign nonce_field = nonce_q;
`endif

    assign block_out   = {hdr_q, nonce_field};
    assign block_valid = valid_q;
    assign nonce_cur   = nonce_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign exhausted   = exh_q;

endmodule
